// File: rtl/btn_press_classifier.sv
// btn_press_classifier
// Turns the debounced level of one button into single-cycle press events
// for the game-control FSM. Events are press start, short press, long press,
// and auto-repeat while the button is held. A button that is already held when
// the block comes out of reset, or when enable returns, is ignored until it has
// been released once.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high
//   enable_i       classifier enable; low forces the disarmed state
//   btn_level_i    debounced button level, 1 = pressed
//   press_start_o  one-cycle pulse when a press is accepted
//   short_press_o  one-cycle pulse on release before LONG_TIME
//   long_press_o   one-cycle pulse when the hold reaches LONG_TIME
//   repeat_tick_o  one-cycle pulse every REPEAT_TIME cycles while long-held
//   held_o         level, high while in the long-hold state
module btn_press_classifier #(
  parameter int unsigned LONG_TIME   = 3000,  // must be >= 2
  parameter int unsigned REPEAT_TIME = 500    // 0 disables repeat
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  input  logic btn_level_i,
  output logic press_start_o,
  output logic short_press_o,
  output logic long_press_o,
  output logic repeat_tick_o,
  output logic held_o
);

  localparam int unsigned MAX_T = (LONG_TIME > REPEAT_TIME) ? LONG_TIME : REPEAT_TIME;
  localparam int unsigned CNT_W = $clog2(MAX_T + 1);

  // Terminal counts. The repeat terminal is guarded so that it does not
  // underflow when repeat is disabled.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((REPEAT_TIME == 0) ? 0 : REPEAT_TIME - 1);
  localparam bit               REP_EN    = (REPEAT_TIME != 0);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    PRESS    = 2'd2,
    LONG     = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_start_q;
  logic             short_press_q;
  logic             long_press_q;
  logic             repeat_tick_q;
  logic             held_q;

  // State machine with registered outputs. The pulses default low on every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= WAIT_LOW;
      cnt_q         <= '0;
      press_start_q <= 1'b0;
      short_press_q <= 1'b0;
      long_press_q  <= 1'b0;
      repeat_tick_q <= 1'b0;
      held_q        <= 1'b0;
    end else begin
      press_start_q <= 1'b0;
      short_press_q <= 1'b0;
      long_press_q  <= 1'b0;
      repeat_tick_q <= 1'b0;

      if (!enable_i) begin
        // Disarm. A release or threshold on this same edge is dropped.
        state_q <= WAIT_LOW;
        cnt_q   <= '0;
        held_q  <= 1'b0;
      end else begin
        unique case (state_q)
          WAIT_LOW: begin
            // The button must be seen low once before a press is accepted.
            if (!btn_level_i) state_q <= IDLE;
          end

          IDLE: begin
            if (btn_level_i) begin
              state_q       <= PRESS;
              cnt_q         <= '0;
              press_start_q <= 1'b1;
            end
          end

          PRESS: begin
            // A release takes priority over reaching the long threshold.
            if (!btn_level_i) begin
              state_q       <= IDLE;
              cnt_q         <= '0;
              short_press_q <= 1'b1;
            end else if (cnt_q == LONG_LAST) begin
              state_q      <= LONG;
              cnt_q        <= '0;
              long_press_q <= 1'b1;
              held_q       <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end

          LONG: begin
            if (!btn_level_i) begin
              // Releasing after a long hold produces no event.
              state_q <= IDLE;
              cnt_q   <= '0;
              held_q  <= 1'b0;
            end else if (REP_EN) begin
              if (cnt_q == REP_LAST) begin
                cnt_q         <= '0;
                repeat_tick_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else begin
              cnt_q <= '0;
            end
          end

          default: begin
            state_q <= WAIT_LOW;
            cnt_q   <= '0;
            held_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign press_start_o = press_start_q;
  assign short_press_o = short_press_q;
  assign long_press_o  = long_press_q;
  assign repeat_tick_o = repeat_tick_q;
  assign held_o        = held_q;

endmodule

// File: tb/tb_btn_press_classifier.sv
// Bench for btn_press_classifier. dut1 uses LONG_TIME=10 and REPEAT_TIME=4.
// dut2 uses LONG_TIME=10 and REPEAT_TIME=0. Both DUTs share the same inputs.
// Output vectors are packed as {press_start, short_press, long_press, repeat_tick, held}.
module tb_btn_press_classifier;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic btn;

  logic ps1, sp1, lp1, rt1, h1;
  logic ps2, sp2, lp2, rt2, h2;
  logic [4:0] o1, o2;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [4:0] Z = 5'b00000;
  localparam logic [4:0] P = 5'b10000;
  localparam logic [4:0] S = 5'b01000;
  localparam logic [4:0] H = 5'b00001;

  always #5 clk = ~clk;

  btn_press_classifier #(.LONG_TIME(10), .REPEAT_TIME(4)) dut1 (
    .clk(clk), .reset(reset), .enable_i(enable), .btn_level_i(btn),
    .press_start_o(ps1), .short_press_o(sp1), .long_press_o(lp1),
    .repeat_tick_o(rt1), .held_o(h1)
  );

  btn_press_classifier #(.LONG_TIME(10), .REPEAT_TIME(0)) dut2 (
    .clk(clk), .reset(reset), .enable_i(enable), .btn_level_i(btn),
    .press_start_o(ps2), .short_press_o(sp2), .long_press_o(lp2),
    .repeat_tick_o(rt2), .held_o(h2)
  );

  assign o1 = {ps1, sp1, lp1, rt1, h1};
  assign o2 = {ps2, sp2, lp2, rt2, h2};

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic       b;
    logic [4:0] exp1;
    logic [4:0] exp2;
  } vec_t;

  vec_t vq[$];

  function automatic void add(string nm, logic r, logic e, logic b, logic [4:0] x);
    vec_t v;
    v.name = nm; v.rst = r; v.en = e; v.b = b; v.exp1 = x; v.exp2 = x;
    vq.push_back(v);
  endfunction

  task automatic check(string nm, logic [4:0] act, logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Apply inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic step(logic r, logic e, logic b);
    reset = r; enable = e; btn = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; btn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_d1", o1, Z);
    check("reset_d2", o2, Z);

    // Short press
    add("s1_low0", 0, 1, 0, Z);
    add("s1_low1", 0, 1, 0, Z);
    add("s1_press", 0, 1, 1, P);
    add("s1_hold1", 0, 1, 1, Z);
    add("s1_hold2", 0, 1, 1, Z);
    add("s1_short", 0, 1, 0, S);
    add("s1_after", 0, 1, 0, Z);
    // Release on the edge that would otherwise fire long_press
    add("thr_press", 0, 1, 1, P);
    for (int i = 0; i < 9; i++) add("thr_hold", 0, 1, 1, Z);
    add("thr_rel_short", 0, 1, 0, S);
    add("thr_after", 0, 1, 0, Z);
    // Enable drops on the threshold edge, so no pulse fires
    add("enthr_press", 0, 1, 1, P);
    for (int i = 0; i < 9; i++) add("enthr_hold", 0, 1, 1, Z);
    add("enthr_drop", 0, 0, 1, Z);
    add("enthr_off_low", 0, 0, 0, Z);
    add("enthr_rearm", 0, 1, 0, Z);
    // Enable drops during a press and returns while the button is still held
    add("en_press", 0, 1, 1, P);
    for (int i = 0; i < 4; i++) add("en_hold", 0, 1, 1, Z);
    for (int i = 0; i < 3; i++) add("en_off", 0, 0, 1, Z);
    for (int i = 0; i < 12; i++) add("en_back_held", 0, 1, 1, Z);
    add("en_release", 0, 1, 0, Z);
    add("en_repress", 0, 1, 1, P);
    add("en_reshort", 0, 1, 0, S);
    add("en_idle", 0, 1, 0, Z);
    // Button held through reset
    for (int i = 0; i < 3; i++) add("rst_held", 1, 1, 1, Z);
    for (int i = 0; i < 15; i++) add("post_rst_held", 0, 1, 1, Z);
    add("post_rst_low", 0, 1, 0, Z);
    add("post_rst_press", 0, 1, 1, P);
    add("post_rst_short", 0, 1, 0, S);
    add("post_rst_idle", 0, 1, 0, Z);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].en, vq[i].b);
      check({vq[i].name, "_d1"}, o1, vq[i].exp1);
      check({vq[i].name, "_d2"}, o2, vq[i].exp2);
    end

    // Long hold: dut1 repeats at +14, +18, ...; dut2 never repeats
    for (int k = 0; k < 30; k++) begin
      logic rep;
      step(0, 1, 1);
      rep = (k > 10) && ((k - 10) % 4 == 0);
      check($sformatf("hold_k%0d_d1", k), o1, {k == 0, 1'b0, k == 10, rep, k >= 10});
      check($sformatf("hold_k%0d_d2", k), o2, {k == 0, 1'b0, k == 10, 1'b0, k >= 10});
    end
    step(0, 1, 0);
    check("hold_release_d1", o1, Z);
    check("hold_release_d2", o2, Z);
    step(0, 1, 0);
    check("hold_idle_d1", o1, Z);

    // Asynchronous reset during a long hold
    for (int k = 0; k < 13; k++) step(0, 1, 1);
    check("mid_long_held_d1", o1, H);
    check("mid_long_held_d2", o2, H);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_d1", o1, Z);
    check("async_rst_d2", o2, Z);
    step(1, 1, 1);
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 1);
      check("post_async_held_d1", o1, Z);
    end
    step(0, 1, 0);
    check("post_async_low_d1", o1, Z);
    step(0, 1, 1);
    check("post_async_press_d1", o1, P);
    check("post_async_press_d2", o2, P);
    step(0, 1, 0);
    check("post_async_short_d1", o1, S);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
